// File: rtl/lsu_mem_initiator.sv
// ----------------------------------------------------------------------------
// lsu_mem_initiator
//   Takes one load/store from the core's memory stage and issues it as a
//   single word-aligned request with byte enables. Once the memory accepts a
//   load, the module waits DATA_LATENCY cycles and then aligns and extends
//   the returned data. The core is stalled until the access completes.
//
// Parameters
//   DATA_LATENCY     cycles from acceptance (mem_req_o & mem_ready_i) to a
//                    valid mem_rd_i; legal range 1..4
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   core_req_i       load/store request, held until core_stall_o is low
//   core_we_i        1 = store, 0 = load
//   core_size_i      funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU (3/6/7 act as W)
//   core_addr_i      byte address
//   core_wd_i        store data, right-justified
//   core_rd_o        aligned and extended load result, valid in DONE
//   core_stall_o     high while a request is pending and not yet DONE
//   core_misalign_o  one-cycle pulse for a trapped misaligned access
//   mem_req_o        memory request
//   mem_we_o         memory write enable
//   mem_be_o         byte enables
//   mem_addr_o       word-aligned address
//   mem_wd_o         lane-replicated write data
//   mem_rd_i         memory read word
//   mem_ready_i      memory accepts the request this cycle
//
// Build option
//   MISALIGN_TRAP_EN defined: a misaligned H/W access goes straight from
//   IDLE to DONE without touching memory and pulses core_misalign_o.
//   Undefined: low address bits are ignored for lane selection.
// ----------------------------------------------------------------------------
module lsu_mem_initiator #(
    parameter int DATA_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [2:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    logic [31:0] r_rd;
    logic [1:0]  r_cnt;

    logic        w_is_byte;
    logic        w_is_half;
    logic        w_in_req;
    logic        w_trap_in;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [3:0]  w_be_store;
    logic [31:0] w_wd_store;

    // The low two funct3 bits give the access width; bit 2 only marks
    // unsigned loads, so BU/HU share the B/H lane logic.
    assign w_is_byte = (r_size[1:0] == 2'b00);
    assign w_is_half = (r_size[1:0] == 2'b01);
    assign w_in_req  = (r_state == S_REQ);

`ifdef MISALIGN_TRAP_EN
    logic r_misalign;

    // Judged on the incoming request so a trapped access never reaches REQ.
    assign w_trap_in = ((core_size_i[1:0] == 2'b01) & core_addr_i[0]) |
                       (core_size_i[1] & (core_addr_i[1:0] != 2'b00));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_misalign <= 1'b0;
        end else if (r_state == S_IDLE && core_req_i) begin
            r_misalign <= w_trap_in;
        end
    end

    assign core_misalign_o = (r_state == S_DONE) & r_misalign;
`else
    assign w_trap_in       = 1'b0;
    assign core_misalign_o = 1'b0;
`endif

    // Load path: pick the addressed byte/half out of the returned word.
    always_comb begin
        w_byte = mem_rd_i[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_addr[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        if (w_is_byte) begin
            w_load_data = {{24{~r_size[2] & w_byte[7]}}, w_byte};
        end else if (w_is_half) begin
            w_load_data = {{16{~r_size[2] & w_half[15]}}, w_half};
        end else begin
            w_load_data = mem_rd_i;
        end
    end

    // Store path: replicate the data over every lane so the enabled lane
    // always carries the right bytes regardless of the offset.
    always_comb begin
        if (w_is_byte) begin
            w_be_store = 4'b0001 << r_addr[1:0];
            w_wd_store = {4{r_wd[7:0]}};
        end else if (w_is_half) begin
            w_be_store = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wd_store = {2{r_wd[15:0]}};
        end else begin
            w_be_store = 4'b1111;
            w_wd_store = r_wd;
        end
    end

    // Memory-side outputs are gated to REQ so they read as zero otherwise.
    assign mem_req_o    = w_in_req;
    assign mem_we_o     = w_in_req & r_we;
    assign mem_be_o     = w_in_req ? (r_we ? w_be_store : 4'b1111) : 4'b0000;
    assign mem_addr_o   = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign mem_wd_o     = (w_in_req & r_we) ? w_wd_store : 32'h0;
    assign core_stall_o = core_req_i & (r_state != S_DONE);
    assign core_rd_o    = r_rd;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (core_req_i) begin
                    w_next = w_trap_in ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ready_i) begin
                    w_next = r_we ? S_DONE : S_RESP;
                end
            end
            S_RESP: begin
                if (r_cnt == 2'd0) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state and datapath registers use non-blocking assignments so
    // every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_size  <= 3'd0;
            r_addr  <= 32'h0;
            r_wd    <= 32'h0;
            r_rd    <= 32'h0;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (core_req_i) begin
                        r_we   <= core_we_i;
                        r_size <= core_size_i;
                        r_addr <= core_addr_i;
                        r_wd   <= core_wd_i;
                    end
                end
                S_REQ: begin
                    if (mem_ready_i && !r_we) begin
                        r_cnt <= 2'(DATA_LATENCY - 1);
                    end
                end
                S_RESP: begin
                    if (r_cnt == 2'd0) begin
                        r_rd <= w_load_data;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
